// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 digest serializer.
// Holds the serializer state encoding and the nibble-to-ASCII mapping.
package sha256_pkg;

    localparam int         DIGEST_BYTES = 32;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } ser_state_t;

    // Lowercase hex: 0-9 -> '0'..'9', a-f -> 'a'..'f'
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h57 + {4'h0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/sha256_hex_encoder.sv
// Combinational byte-to-ASCII encoder: picks one nibble of a byte and
// returns its lowercase hex character.
module sha256_hex_encoder
    import sha256_pkg::*;
(
    input  logic [7:0] data_byte,
    input  logic       nib_sel,
    output logic [7:0] ascii_char
);

    // nib_sel = 0 selects the high nibble, 1 the low nibble
    always_comb begin
        ascii_char = 8'h00;
        if (nib_sel) begin
            ascii_char = nibble_to_hex(data_byte[3:0]);
        end else begin
            ascii_char = nibble_to_hex(data_byte[7:4]);
        end
    end

endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures a finished SHA-256 digest and streams it out one character per
// valid/ready handshake, as raw bytes or lowercase hex with optional newline.
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int DIGEST_BITS    = 8 * DIGEST_BYTES,
    parameter int HEX_MODE       = 1,
    parameter int APPEND_NEWLINE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   digest_valid,
    input  logic [DIGEST_BITS-1:0] digest,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   overrun
);

    localparam int NUM_BYTES = DIGEST_BITS / 8;
    localparam int NUM_CHARS = (HEX_MODE != 0) ? 2 * NUM_BYTES : NUM_BYTES;
    localparam int CNT_W     = $clog2(2 * NUM_BYTES + 1);
    localparam bit IS_HEX    = (HEX_MODE != 0);
    localparam bit USE_LF    = (HEX_MODE != 0) && (APPEND_NEWLINE != 0);
    localparam logic [CNT_W-1:0] LAST_CHAR = CNT_W'(NUM_CHARS - 1);

    ser_state_t             state_r, state_s;
    logic [DIGEST_BITS-1:0] shift_r, shift_s;
    logic [CNT_W-1:0]       beat_cnt_r, beat_cnt_s, cnt_inc_s;
    logic                   nib_sel_r, nib_sel_s;
    logic [7:0]             tx_data_s;
    logic                   tx_valid_s, tx_last_s, busy_s, overrun_s;
    logic                   hs_s;
    logic [7:0]             enc_byte_s, enc_char_s, next_char_s;
    logic                   enc_nib_s;
    logic [DIGEST_BITS-1:0] shift_adv_s;

    assign hs_s        = tx_valid && tx_ready;
    assign cnt_inc_s   = beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign shift_adv_s = {shift_r[DIGEST_BITS-9:0], 8'h00};
    assign next_char_s = IS_HEX ? enc_char_s : enc_byte_s;

    sha256_hex_encoder u_hex_encoder (
        .data_byte  (enc_byte_s),
        .nib_sel    (enc_nib_s),
        .ascii_char (enc_char_s)
    );

    // Select the source byte/nibble of the character that follows the current one
    always_comb begin
        enc_byte_s = shift_r[DIGEST_BITS-1 -: 8];
        enc_nib_s  = 1'b0;
        if (state_r == IDLE) begin
            enc_byte_s = digest[DIGEST_BITS-1 -: 8];
        end else if (IS_HEX && !nib_sel_r) begin
            enc_byte_s = shift_r[DIGEST_BITS-1 -: 8];
            enc_nib_s  = 1'b1;
        end else begin
            enc_byte_s = shift_r[DIGEST_BITS-9 -: 8];
        end
    end

    // Next-state and next-output logic; outputs are registered so they hold under backpressure
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        beat_cnt_s = beat_cnt_r;
        nib_sel_s  = nib_sel_r;
        tx_data_s  = tx_data;
        tx_valid_s = tx_valid;
        tx_last_s  = tx_last;

        if (digest_valid && (state_r != IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun;
        end

        case (state_r)
            IDLE: begin
                if (digest_valid) begin
                    state_s    = SEND;
                    shift_s    = digest;
                    beat_cnt_s = {CNT_W{1'b0}};
                    nib_sel_s  = 1'b0;
                    tx_data_s  = next_char_s;
                    tx_valid_s = 1'b1;
                    tx_last_s  = (NUM_CHARS == 1) && !USE_LF;
                end else begin
                    tx_valid_s = 1'b0;
                    tx_last_s  = 1'b0;
                end
            end
            SEND: begin
                if (hs_s && (beat_cnt_r == LAST_CHAR)) begin
                    if (USE_LF) begin
                        state_s    = TERM;
                        tx_data_s  = ASCII_LF;
                        tx_valid_s = 1'b1;
                        tx_last_s  = 1'b1;
                    end else begin
                        state_s    = IDLE;
                        tx_data_s  = 8'h00;
                        tx_valid_s = 1'b0;
                        tx_last_s  = 1'b0;
                    end
                end else if (hs_s) begin
                    beat_cnt_s = cnt_inc_s;
                    tx_data_s  = next_char_s;
                    tx_last_s  = (cnt_inc_s == LAST_CHAR) && !USE_LF;
                    if (IS_HEX) begin
                        // Shift only once both nibbles of the top byte have gone out
                        nib_sel_s = !nib_sel_r;
                        if (nib_sel_r) begin
                            shift_s = shift_adv_s;
                        end else begin
                            shift_s = shift_r;
                        end
                    end else begin
                        nib_sel_s = 1'b0;
                        shift_s   = shift_adv_s;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            TERM: begin
                if (hs_s) begin
                    state_s    = IDLE;
                    tx_data_s  = 8'h00;
                    tx_valid_s = 1'b0;
                    tx_last_s  = 1'b0;
                end else begin
                    state_s = TERM;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_data_s  = 8'h00;
                tx_valid_s = 1'b0;
                tx_last_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= {DIGEST_BITS{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            nib_sel_r  <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            beat_cnt_r <= beat_cnt_s;
            nib_sel_r  <= nib_sel_s;
            tx_data    <= tx_data_s;
            tx_valid   <= tx_valid_s;
            tx_last    <= tx_last_s;
            busy       <= busy_s;
            overrun    <= overrun_s;
        end
    end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Self-checking bench: a hex+newline instance and a raw instance are driven
// with directed and random digests and compared against a string-level model.
module tb_sha256_digest_serializer;

    localparam logic [255:0] HELLO =
        256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
    localparam logic [255:0] ONES = {256{1'b1}};

    logic         clk = 1'b0;
    logic         reset, dv_hex, dv_raw, tx_ready;
    logic [255:0] digest;
    logic         hx_busy, hx_valid, hx_last, hx_ovr;
    logic [7:0]   hx_data;
    logic         rw_busy, rw_valid, rw_last, rw_ovr;
    logic [7:0]   rw_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_mode = 0;

    logic [7:0] q_hex[$];  bit q_hex_last[$];  int q_hex_cyc[$];
    logic [7:0] q_raw[$];  bit q_raw_last[$];  int q_raw_cyc[$];
    logic [7:0] e_hex[$];  bit e_hex_last[$];
    logic [7:0] e_raw[$];  bit e_raw_last[$];

    logic       hx_pv = 1'b0, hx_pr = 1'b0, hx_pl = 1'b0;
    logic [7:0] hx_pd = 8'h00;
    logic       rw_pv = 1'b0, rw_pr = 1'b0, rw_pl = 1'b0;
    logic [7:0] rw_pd = 8'h00;
    logic [7:0] hx_samp = 8'h00;
    logic       hx_bsamp = 1'b0, rw_bsamp = 1'b0;

    always #5 clk = ~clk;

    sha256_digest_serializer #(.DIGEST_BITS(256), .HEX_MODE(1), .APPEND_NEWLINE(1)) dut_hex (
        .clk(clk), .reset(reset), .digest_valid(dv_hex), .digest(digest),
        .busy(hx_busy), .tx_data(hx_data), .tx_valid(hx_valid), .tx_ready(tx_ready),
        .tx_last(hx_last), .overrun(hx_ovr)
    );

    sha256_digest_serializer #(.DIGEST_BITS(256), .HEX_MODE(0), .APPEND_NEWLINE(1)) dut_raw (
        .clk(clk), .reset(reset), .digest_valid(dv_raw), .digest(digest),
        .busy(rw_busy), .tx_data(rw_data), .tx_valid(rw_valid), .tx_ready(tx_ready),
        .tx_last(rw_last), .overrun(rw_ovr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input int n);
        logic [7:0] r;
        if (n < 10) r = 8'(48 + n);
        else        r = 8'(97 + n - 10);
        return r;
    endfunction

    // Reference: digest bytes MSB first; hex as two lowercase chars plus '\n'
    task automatic add_expected(input logic [255:0] d);
        logic [255:0] t;
        int b;
        for (int i = 0; i < 32; i++) begin
            t = (d >> (8 * (31 - i))) & 256'hFF;
            b = int'(t[7:0]);
            e_hex.push_back(hex_char(b / 16)); e_hex_last.push_back(1'b0);
            e_hex.push_back(hex_char(b % 16)); e_hex_last.push_back(1'b0);
            e_raw.push_back(8'(b));            e_raw_last.push_back(i == 31);
        end
        e_hex.push_back(8'h0A); e_hex_last.push_back(1'b1);
    endtask

    task automatic clear_all();
        q_hex.delete(); q_hex_last.delete(); q_hex_cyc.delete();
        q_raw.delete(); q_raw_last.delete(); q_raw_cyc.delete();
        e_hex.delete(); e_hex_last.delete(); e_raw.delete(); e_raw_last.delete();
    endtask

    task automatic compare_streams(input string tag);
        check_eq({tag, "_hex_len"}, q_hex.size(), e_hex.size());
        check_eq({tag, "_raw_len"}, q_raw.size(), e_raw.size());
        for (int i = 0; i < q_hex.size() && i < e_hex.size(); i++) begin
            check_eq($sformatf("%s_hex_beat%0d", tag, i), q_hex[i], e_hex[i]);
            check_eq($sformatf("%s_hex_last%0d", tag, i), q_hex_last[i], e_hex_last[i]);
        end
        for (int i = 0; i < q_raw.size() && i < e_raw.size(); i++) begin
            check_eq($sformatf("%s_raw_beat%0d", tag, i), q_raw[i], e_raw[i]);
            check_eq($sformatf("%s_raw_last%0d", tag, i), q_raw_last[i], e_raw_last[i]);
        end
    endtask

    // One clock cycle: sample on the falling edge, then advance past the rising edge
    task automatic step();
        @(negedge clk);
        if (hx_pv && !hx_pr) begin
            check_eq("hex_hold_valid", hx_valid, 1'b1);
            check_eq("hex_hold_data", hx_data, hx_pd);
            check_eq("hex_hold_last", hx_last, hx_pl);
        end
        if (rw_pv && !rw_pr) begin
            check_eq("raw_hold_valid", rw_valid, 1'b1);
            check_eq("raw_hold_data", rw_data, rw_pd);
            check_eq("raw_hold_last", rw_last, rw_pl);
        end
        if (hx_valid && tx_ready) begin
            q_hex.push_back(hx_data); q_hex_last.push_back(hx_last); q_hex_cyc.push_back(cyc);
        end
        if (rw_valid && tx_ready) begin
            q_raw.push_back(rw_data); q_raw_last.push_back(rw_last); q_raw_cyc.push_back(cyc);
        end
        hx_pv = hx_valid; hx_pr = tx_ready; hx_pd = hx_data; hx_pl = hx_last;
        rw_pv = rw_valid; rw_pr = tx_ready; rw_pd = rw_data; rw_pl = rw_last;
        hx_samp = hx_data; hx_bsamp = hx_busy; rw_bsamp = rw_busy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse(input logic [255:0] d, input bit h, input bit r);
        digest = d; dv_hex = h; dv_raw = r;
        step();
        dv_hex = 1'b0; dv_raw = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        int s = 0;
        while ((hx_busy || rw_busy) && n < bound) begin
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: begin
                    if (q_hex.size() == 0) begin
                        tx_ready = 1'b1;
                    end else begin
                        s = cyc - q_hex_cyc[0];
                        tx_ready = (s <= 3) ? 1'b0 : !s[0];
                    end
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            n++;
            if (ready_mode == 1 && q_hex.size() == 1 && s == 2)
                check_eq("stall_data", hx_samp, 8'h39);
        end
        check_eq("drain_timeout", 32'(hx_busy || rw_busy), 32'd0);
        tx_ready = 1'b1;
    endtask

    function automatic logic [255:0] rand_digest();
        logic [255:0] d = 256'h0;
        for (int k = 0; k < 8; k++) d = {d[223:0], $urandom()};
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, n, c;
        logic [255:0] nd;

        reset = 1'b1; dv_hex = 1'b0; dv_raw = 1'b0; digest = 256'h0; tx_ready = 1'b1;
        #1;
        step(); step();
        check_eq("rst_hex_busy", hx_busy, 1'b0);
        check_eq("rst_hex_valid", hx_valid, 1'b0);
        check_eq("rst_hex_last", hx_last, 1'b0);
        check_eq("rst_hex_ovr", hx_ovr, 1'b0);
        check_eq("rst_hex_data", hx_data, 8'h00);
        check_eq("rst_raw_busy", rw_busy, 1'b0);
        check_eq("rst_raw_valid", rw_valid, 1'b0);
        check_eq("rst_raw_ovr", rw_ovr, 1'b0);
        reset = 1'b0;
        step();

        // Hello-world digest, no backpressure
        clear_all();
        p = cyc;
        pulse(HELLO, 1'b1, 1'b1);
        check_eq("lat_hex_valid", hx_valid, 1'b1);
        check_eq("lat_raw_valid", rw_valid, 1'b1);
        n = 0;
        while (hx_busy && n < 200) begin step(); n++; end
        check_eq("hex_busy_fall_cyc", cyc, p + 66);
        drain(200);
        add_expected(HELLO);
        compare_streams("hello");
        if (q_hex.size() == 65 && q_raw.size() == 32) begin
            check_eq("hex_b0", q_hex[0], 8'h62);
            check_eq("hex_b1", q_hex[1], 8'h39);
            check_eq("hex_b2", q_hex[2], 8'h34);
            check_eq("hex_b3", q_hex[3], 8'h64);
            check_eq("hex_b62", q_hex[62], 8'h65);
            check_eq("hex_b63", q_hex[63], 8'h39);
            check_eq("hex_b64", q_hex[64], 8'h0A);
            check_eq("hex_last64", q_hex_last[64], 1'b1);
            check_eq("raw_b0", q_raw[0], 8'hB9);
            check_eq("raw_b31", q_raw[31], 8'hE9);
            check_eq("hex_first_cyc", q_hex_cyc[0], p + 1);
            check_eq("hex_final_cyc", q_hex_cyc[64], p + 65);
            check_eq("raw_first_cyc", q_raw_cyc[0], p + 1);
            check_eq("raw_final_cyc", q_raw_cyc[31], p + 32);
        end else begin
            check_eq("hello_sizes_known", 32'd0, 32'd1);
        end
        check_eq("no_false_ovr_hex", hx_ovr, 1'b0);
        check_eq("no_false_ovr_raw", rw_ovr, 1'b0);

        // Backpressure
        clear_all();
        ready_mode = 1;
        pulse(HELLO, 1'b1, 1'b1);
        drain(400);
        ready_mode = 0;
        add_expected(HELLO);
        compare_streams("bp");

        // Overrun mid-stream and on the final handshake, then restart on first idle cycle
        clear_all();
        nd = rand_digest();
        p = cyc;
        pulse(HELLO, 1'b1, 1'b1);
        while (cyc <= p + 66) begin
            c = cyc - p;
            dv_hex = (c == 10 || c == 65 || c == 66);
            dv_raw = (c == 10 || c == 32 || c == 66);
            digest = (c == 66) ? nd : ONES;
            step();
            if (c == 66) begin
                check_eq("ovr_hex_idle", hx_bsamp, 1'b0);
                check_eq("ovr_raw_idle", rw_bsamp, 1'b0);
            end
        end
        dv_hex = 1'b0; dv_raw = 1'b0;
        drain(300);
        add_expected(HELLO);
        add_expected(nd);
        compare_streams("ovr");
        check_eq("ovr_hex_set", hx_ovr, 1'b1);
        check_eq("ovr_raw_set", rw_ovr, 1'b1);
        if (q_hex.size() > 65) check_eq("ovr_restart_cyc", q_hex_cyc[65], p + 67);
        else                   check_eq("ovr_restart_seen", q_hex.size(), 130);

        // Reset mid-stream at beat 10
        clear_all();
        pulse(HELLO, 1'b1, 1'b1);
        n = 0;
        while (q_hex.size() < 10 && n < 100) begin step(); n++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_mid_hex_valid", hx_valid, 1'b0);
        check_eq("rst_mid_hex_busy", hx_busy, 1'b0);
        check_eq("rst_mid_hex_ovr", hx_ovr, 1'b0);
        check_eq("rst_mid_raw_valid", rw_valid, 1'b0);
        check_eq("rst_mid_raw_ovr", rw_ovr, 1'b0);
        clear_all();
        pulse(256'h0, 1'b1, 1'b1);
        drain(200);
        add_expected(256'h0);
        compare_streams("zero");

        // All-ones digest followed by a back-to-back digest on the first idle cycle
        clear_all();
        nd = rand_digest();
        pulse(ONES, 1'b1, 1'b1);
        n = 0;
        while (hx_busy && n < 200) begin step(); n++; end
        p = cyc;
        pulse(nd, 1'b1, 1'b1);
        drain(200);
        add_expected(ONES);
        add_expected(nd);
        compare_streams("b2b");
        if (q_hex.size() > 65) begin
            check_eq("b2b_prev_cyc", q_hex_cyc[64], p - 1);
            check_eq("b2b_next_cyc", q_hex_cyc[65], p + 1);
        end else begin
            check_eq("b2b_seen", q_hex.size(), 130);
        end

        // Random digests under random backpressure
        for (int r = 0; r < 4; r++) begin
            clear_all();
            nd = rand_digest();
            ready_mode = 2;
            pulse(nd, 1'b1, 1'b1);
            drain(1000);
            ready_mode = 0;
            add_expected(nd);
            compare_streams($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
